fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
Upstream neighbour of the instruction-cache fetch stage. Generates sequential word-aligned fetch addresses and pushes them into the address FIFO; that FIFO is consumed by the cache fetch stage, which writes fetched instructions into the instruction FIFO.
On a jump or JTAG reset, it flushes the address FIFO and restarts at the new PC.
It caps the number of in-flight fetches with a credit counter, decremented when decode pops an instruction, so the instruction FIFO cannot be overrun.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
MAX_INFLIGHT, 8, maximum addresses issued but not yet popped by decode.
CNT_W, 4, credit counter width; must hold MAX_INFLIGHT.

Ports:
clk  input  1  core clock; single clock domain.
rst  input  1  synchronous, active-high reset.
jtag_reset_flag_i  input  1  same effect as rst.
jump_flag_i  input  1  redirect request from ex/ctrl.
jump_addr_i  input  32  redirect target.
hold_flag_i  input  1  pipeline hold; suppresses pushes.
inst_pop_i  input  1  decode popped one instruction from the instruction FIFO.
addr_fifo_full  input  1  address FIFO full.
addr_fifo_w  output  32  address to push; equals pc_q.
addr_fifo_wen  output  1  push strobe, combinational.
addr_fifo_rstn  output  1  active-low address FIFO flush.
pc_o  output  32  next address to be issued (debug).
inflight_o  output  CNT_W  current credit count (debug).

Behaviour:
- Reset is synchronous and active-high; jtag_reset_flag_i is ORed into rst.
- Reset values: state=S_FLUSH, pc_q=RESET_PC, inflight=0, addr_fifo_wen=0, addr_fifo_rstn=0.
- States:
  - S_FLUSH: addr_fifo_rstn=0, no push, inst_pop_i ignored; always goes to S_RUN next cycle.
  - S_RUN: normal issue.
  - S_HOLD: entered when hold_flag_i=1 in S_RUN; returns to S_RUN the cycle after hold_flag_i=0.
- addr_fifo_rstn = (state != S_FLUSH). It is low for every cycle rst is sampled high, plus exactly one cycle after rst falls.
- push = (state==S_RUN) & ~hold_flag_i & ~addr_fifo_full & (inflight < MAX_INFLIGHT) & ~jump_flag_i.
- addr_fifo_wen = push, same cycle. addr_fifo_w = pc_q.
- On push: pc_q <= pc_q + 4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
- Jump (jump_flag_i=1, not in reset):
  - pc_q <= {jump_addr_i[31:2], 2'b00};
  - state <= S_FLUSH; inflight <= 0;
  - no push that cycle.
  - Jump beats push, pop and hold.
  - A jump arriving in S_FLUSH reloads pc_q and stays in S_FLUSH one more cycle.
  - Consecutive jump cycles: the last target wins.
- Credit counter:
  - push & ~pop: +1.
  - pop & ~push: −1.
  - Both, or neither: unchanged.
  - A pop at inflight=0 is ignored (no underflow).
  - inflight never exceeds MAX_INFLIGHT.
- Latency:
  - First push occurs two cycles after rst falls: one S_FLUSH cycle, then S_RUN.
  - After a jump, the first push of the target is on the second cycle after the jump cycle.
- Hold: pc_q and inflight hold their values (pops still count); no push.
- Stall on addr_fifo_full or a full credit counter: pc_q unchanged, addr_fifo_w stable, addr_fifo_wen=0.

Decomposition:
- Shared package: state encoding (S_FLUSH, S_RUN, S_HOLD); the MAX_INFLIGHT default; the fetch-step constant 4; InstAddrBus from the existing defines.
- One sub-module: fetch_credit_cnt, a saturating up/down counter with clear, driven by push/pop/clear, outputting count and at_max.

Test Plan:
1. Reset release, FIFO never full, inst_pop_i=1 every cycle → after one rstn-low cycle, pushes 0x0, 0x4, 0x8, … on consecutive cycles; inflight stays ≤1.
2. No pops, FIFO not full → exactly 8 pushes (0x0–0x1C), then wen=0 with pc_o=0x20 held; one pop → one push of 0x20.
3. addr_fifo_full high for 3 cycles mid-stream at pc 0x40 → wen=0, addr_fifo_w=0x40 stable; push of 0x40 on the cycle full drops.
4. Jump to 0x102 while inflight=5 → rstn low the next cycle, inflight=0, next push 0x100, then 0x104.
5. RESET_PC=32'hFFFF_FFF8, pops every cycle → pushes FFFF_FFF8, FFFF_FFFC, 0x0, 0x4.
6. Push and pop in the same cycle at inflight=3 → inflight stays 3; jump and hold asserted in the same cycle → jump taken, S_FLUSH entered.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch address generator.
package fetch_pc_gen_pkg;

    localparam int unsigned InstAddrBus        = 32;
    localparam int unsigned MaxInflightDefault = 8;
    localparam logic [InstAddrBus-1:0] FetchStep = 32'd4;

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_credit_cnt.sv
// Saturating up/down credit counter with synchronous clear.
module fetch_credit_cnt #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o,
    output logic         at_max_o
);

    localparam logic [W-1:0] MaxCnt = W'(MAX);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push_i && !pop_i && count_q != MaxCnt) begin
            count_d = count_q + W'(1);
        end else if (pop_i && !push_i && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q >= MaxCnt);

endmodule

// File: rtl/fetch_pc_gen.sv
// Sequential fetch address generator feeding the address FIFO, with jump
// redirect/flush and a credit cap on addresses not yet consumed by decode.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned            MAX_INFLIGHT = MaxInflightDefault,
    parameter int unsigned            CNT_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jtag_reset_flag_i,
    input  logic                   jump_flag_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    input  logic                   hold_flag_i,
    input  logic                   inst_pop_i,
    input  logic                   addr_fifo_full,
    output logic [InstAddrBus-1:0] addr_fifo_w,
    output logic                   addr_fifo_wen,
    output logic                   addr_fifo_rstn,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [CNT_W-1:0]       inflight_o
);

    state_e                 state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic                   rst_any;
    logic                   push;
    logic                   pop_eff;
    logic                   at_max;

    assign rst_any = rst | jtag_reset_flag_i;

    assign push = ~rst_any & (state_q == S_RUN) & ~hold_flag_i & ~addr_fifo_full &
                  ~at_max & ~jump_flag_i;

    // Pops seen while flushing belong to the discarded stream.
    assign pop_eff = inst_pop_i & (state_q != S_FLUSH);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (jump_flag_i) begin
            state_d = S_FLUSH;
            pc_d    = {jump_addr_i[InstAddrBus-1:2], 2'b00};
        end else begin
            unique case (state_q)
                S_FLUSH: state_d = S_RUN;
                S_RUN:   if (hold_flag_i) state_d = S_HOLD;
                S_HOLD:  if (!hold_flag_i) state_d = S_RUN;
                default: state_d = S_FLUSH;
            endcase
            if (push) begin
                pc_d = pc_q + FetchStep;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_any) begin
            state_q <= S_FLUSH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_credit_cnt #(
        .MAX (MAX_INFLIGHT),
        .W   (CNT_W)
    ) u_credit (
        .clk      (clk),
        .rst      (rst_any),
        .push_i   (push),
        .pop_i    (pop_eff),
        .clear_i  (jump_flag_i),
        .count_o  (inflight_o),
        .at_max_o (at_max)
    );

    assign addr_fifo_w    = pc_q;
    assign addr_fifo_wen  = push;
    assign addr_fifo_rstn = ~rst_any & (state_q != S_FLUSH);
    assign pc_o           = pc_q;

endmodule
